// File: rtl/muldiv_pkg.sv
// Shared types and default iteration budgets for the Mult/Div sequencer.
package muldiv_pkg;

   localparam int unsigned WORD_W          = 32;
   localparam int unsigned DEF_MULT_CYCLES = 33;
   localparam int unsigned DEF_DIV_CYCLES  = 34;
   localparam int unsigned DEF_CNT_W       = 6;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN_MULT = 2'd1,
      RUN_DIV  = 2'd2,
      CAPTURE  = 2'd3
   } state_t;

endpackage

// File: rtl/muldiv_cnt.sv
// Iteration counter: cleared on load, counts while enabled, flags cnt == limit.
module muldiv_cnt #(
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] limit,
   output logic             tc_c
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tc_c = (cnt == limit);

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the iterative Mult/Div units: operand latch, run timing, HI/LO capture.
// Optional MULDIV_ABORT_EN adds an Abort input that cancels a running operation.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic  Clock,
   input  logic  Reset,
   input  logic  MultStart,
   input  logic  DivStart,
   input  word_t FromA,
   input  word_t FromB,
   input  logic  HiLoRead,
   input  word_t MultHI,
   input  word_t MultLO,
   input  word_t DivHI,
   input  word_t DivLO,
   input  logic  UnitDiv0,
`ifdef MULDIV_ABORT_EN
   input  logic  Abort,
`endif
   output word_t OpA,
   output word_t OpB,
   output logic  MultCtrl,
   output logic  DivCtrl,
   output logic  UnitRst,
   output word_t HIReg,
   output word_t LOReg,
   output logic  Busy,
   output logic  Done,
   output logic  Div0Exc,
   output logic  Collision,
   output logic  ReadStall
);

   state_t state, state_nxt;

   logic mult_ctrl_nxt, div_ctrl_nxt, unit_rst_nxt, busy_nxt;
   logic done_nxt, div0_nxt, coll_nxt;
   logic ops_load, hilo_load, cnt_load, cnt_en, tc_c, abort_req;
   logic [CNT_W-1:0] cnt_limit;

`ifdef MULDIV_ABORT_EN
   assign abort_req = Abort;
`else
   assign abort_req = 1'b0;
`endif

   assign cnt_limit = (state == RUN_DIV) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

   muldiv_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk   (Clock),
      .rst_n (Reset),
      .load  (cnt_load),
      .en    (cnt_en),
      .limit (cnt_limit),
      .tc_c  (tc_c)
   );

   // State and control-output registers
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state     <= IDLE;
         MultCtrl  <= 1'b0;
         DivCtrl   <= 1'b0;
         UnitRst   <= 1'b1;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         Div0Exc   <= 1'b0;
         Collision <= 1'b0;
      end else begin
         state     <= state_nxt;
         MultCtrl  <= mult_ctrl_nxt;
         DivCtrl   <= div_ctrl_nxt;
         UnitRst   <= unit_rst_nxt;
         Busy      <= busy_nxt;
         Done      <= done_nxt;
         Div0Exc   <= div0_nxt;
         Collision <= coll_nxt;
      end
   end

   // Next-state and next-output decode
   always_comb begin
      state_nxt     = state;
      mult_ctrl_nxt = MultCtrl;
      div_ctrl_nxt  = DivCtrl;
      unit_rst_nxt  = UnitRst;
      busy_nxt      = Busy;
      done_nxt      = 1'b0;
      div0_nxt      = 1'b0;
      coll_nxt      = 1'b0;
      ops_load      = 1'b0;
      hilo_load     = 1'b0;
      cnt_load      = 1'b0;
      cnt_en        = 1'b0;

      case (state)
         IDLE: begin
            unit_rst_nxt  = 1'b1;
            busy_nxt      = 1'b0;
            mult_ctrl_nxt = 1'b0;
            div_ctrl_nxt  = 1'b0;
            if (MultStart) begin
               state_nxt     = RUN_MULT;
               ops_load      = 1'b1;
               cnt_load      = 1'b1;
               mult_ctrl_nxt = 1'b1;
               busy_nxt      = 1'b1;
               unit_rst_nxt  = 1'b0;
               coll_nxt      = DivStart;
            end else if (DivStart) begin
               // A zero divisor never reaches the Div unit
               if (FromB != '0) begin
                  state_nxt    = RUN_DIV;
                  ops_load     = 1'b1;
                  cnt_load     = 1'b1;
                  div_ctrl_nxt = 1'b1;
                  busy_nxt     = 1'b1;
                  unit_rst_nxt = 1'b0;
               end else begin
                  div0_nxt = 1'b1;
               end
            end
         end

         RUN_MULT, RUN_DIV: begin
            coll_nxt = MultStart | DivStart;
            cnt_en   = 1'b1;
            if (abort_req || (state == RUN_DIV && UnitDiv0)) begin
               state_nxt     = IDLE;
               mult_ctrl_nxt = 1'b0;
               div_ctrl_nxt  = 1'b0;
               busy_nxt      = 1'b0;
               unit_rst_nxt  = 1'b1;
               div0_nxt      = !abort_req;
            end else if (tc_c) begin
               state_nxt = CAPTURE;
            end
         end

         CAPTURE: begin
            coll_nxt      = MultStart | DivStart;
            hilo_load     = 1'b1;
            mult_ctrl_nxt = 1'b0;
            div_ctrl_nxt  = 1'b0;
            busy_nxt      = 1'b0;
            unit_rst_nxt  = 1'b1;
            done_nxt      = 1'b1;
            state_nxt     = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand latches and architectural HI/LO; DivCtrl still marks the active unit in CAPTURE
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         OpA   <= '0;
         OpB   <= '0;
         HIReg <= '0;
         LOReg <= '0;
      end else begin
         if (ops_load) begin
            OpA <= FromA;
            OpB <= FromB;
         end
         if (hilo_load) begin
            HIReg <= DivCtrl ? DivHI : MultHI;
            LOReg <= DivCtrl ? DivLO : MultLO;
         end
      end
   end

   assign ReadStall = HiLoRead & Busy;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl with arithmetic stubs standing in for the Mult/Div units.
module tb_muldiv_ctrl;

   localparam int MULT_N = 33;
   localparam int DIV_N  = 34;

   logic        Clock, Reset, MultStart, DivStart, HiLoRead, UnitDiv0;
   logic [31:0] FromA, FromB, MultHI, MultLO, DivHI, DivLO;
   logic [31:0] OpA, OpB, HIReg, LOReg;
   logic        MultCtrl, DivCtrl, UnitRst, Busy, Done, Div0Exc, Collision, ReadStall;
   logic [63:0] prod;

   int checks = 0;
   int passed = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   muldiv_ctrl dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .MultStart (MultStart),
      .DivStart  (DivStart),
      .FromA     (FromA),
      .FromB     (FromB),
      .HiLoRead  (HiLoRead),
      .MultHI    (MultHI),
      .MultLO    (MultLO),
      .DivHI     (DivHI),
      .DivLO     (DivLO),
      .UnitDiv0  (UnitDiv0),
`ifdef MULDIV_ABORT_EN
      .Abort     (1'b0),
`endif
      .OpA       (OpA),
      .OpB       (OpB),
      .MultCtrl  (MultCtrl),
      .DivCtrl   (DivCtrl),
      .UnitRst   (UnitRst),
      .HIReg     (HIReg),
      .LOReg     (LOReg),
      .Busy      (Busy),
      .Done      (Done),
      .Div0Exc   (Div0Exc),
      .Collision (Collision),
      .ReadStall (ReadStall)
   );

   // Unit stubs: ideal arithmetic on the latched operands
   assign prod   = 64'(OpA) * 64'(OpB);
   assign MultHI = prod[63:32];
   assign MultLO = prod[31:0];
   assign DivLO  = (OpB == 32'd0) ? 32'd0 : OpA / OpB;
   assign DivHI  = (OpB == 32'd0) ? 32'd0 : OpA % OpB;

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      HiLoRead = 1'b1;
      repeat (2) step();
      checks++; if (Busy !== 1'b0)      $display("FAIL reset_busy got %b exp 0", Busy); else passed++;
      checks++; if (MultCtrl !== 1'b0)  $display("FAIL reset_multctrl got %b exp 0", MultCtrl); else passed++;
      checks++; if (DivCtrl !== 1'b0)   $display("FAIL reset_divctrl got %b exp 0", DivCtrl); else passed++;
      checks++; if (UnitRst !== 1'b1)   $display("FAIL reset_unitrst got %b exp 1", UnitRst); else passed++;
      checks++; if (Done !== 1'b0)      $display("FAIL reset_done got %b exp 0", Done); else passed++;
      checks++; if (Div0Exc !== 1'b0)   $display("FAIL reset_div0 got %b exp 0", Div0Exc); else passed++;
      checks++; if (Collision !== 1'b0) $display("FAIL reset_coll got %b exp 0", Collision); else passed++;
      checks++; if ({HIReg, LOReg} !== 64'd0) $display("FAIL reset_hilo got %h_%h exp 0", HIReg, LOReg); else passed++;
      checks++; if ({OpA, OpB} !== 64'd0) $display("FAIL reset_ops got %h_%h exp 0", OpA, OpB); else passed++;
      checks++; if (ReadStall !== 1'b0) $display("FAIL reset_stall got %b exp 0", ReadStall); else passed++;
      HiLoRead = 1'b0;
      Reset = 1'b1;
      step();
   endtask

   // One full operation; the model is the timeline: busy for cycles 0..n, result and Done at n+1
   task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                         input bit both, input int coll_at, input int read_from, input bit cap_start);
      int n;
      int colls;
      bit eb;
      logic [63:0] p;
      logic [31:0] rhi, rlo;
      n = is_div ? DIV_N : MULT_N;
      if (is_div) begin
         rhi = a % b;
         rlo = a / b;
      end else begin
         p = 64'(a) * 64'(b);
         rhi = p[63:32];
         rlo = p[31:0];
      end
      colls = 0;
      FromA = a;
      FromB = b;
      MultStart = !is_div;
      DivStart = is_div | both;
      step();
      checks++; if (OpA !== a || OpB !== b) $display("FAIL op_latch got %h/%h exp %h/%h", OpA, OpB, a, b); else passed++;
      for (int k = 0; k <= n + 1; k++) begin
         HiLoRead = (read_from > 0) && (k >= read_from);
         MultStart = cap_start && (k == n);
         DivStart = (coll_at > 0) && (k == coll_at);
         FromA = $urandom;
         FromB = $urandom;
         #1;
         eb = (k <= n);
         checks++; if (Busy !== eb) $display("FAIL busy cyc=%0d got %b exp %b", k, Busy, eb); else passed++;
         checks++; if (MultCtrl !== (eb && !is_div)) $display("FAIL multctrl cyc=%0d got %b exp %b", k, MultCtrl, eb && !is_div); else passed++;
         checks++; if (DivCtrl !== (eb && is_div)) $display("FAIL divctrl cyc=%0d got %b exp %b", k, DivCtrl, eb && is_div); else passed++;
         checks++; if (UnitRst !== !eb) $display("FAIL unitrst cyc=%0d got %b exp %b", k, UnitRst, !eb); else passed++;
         checks++; if (Done !== (k == n + 1)) $display("FAIL done cyc=%0d got %b exp %b", k, Done, k == n + 1); else passed++;
         checks++; if (ReadStall !== (HiLoRead && eb)) $display("FAIL readstall cyc=%0d got %b exp %b", k, ReadStall, HiLoRead && eb); else passed++;
         if (eb) begin
            checks++; if (HIReg !== exp_hi || LOReg !== exp_lo) $display("FAIL hilo_hold cyc=%0d got %h_%h exp %h_%h", k, HIReg, LOReg, exp_hi, exp_lo); else passed++;
         end else begin
            checks++; if (HIReg !== rhi || LOReg !== rlo) $display("FAIL hilo_result got %h_%h exp %h_%h", HIReg, LOReg, rhi, rlo); else passed++;
         end
         if (Collision === 1'b1) colls++;
         if (k <= n) step();
      end
      MultStart = 1'b0;
      DivStart = 1'b0;
      HiLoRead = 1'b0;
      exp_hi = rhi;
      exp_lo = rlo;
      checks++;
      if (colls !== int'(both) + int'(coll_at > 0) + int'(cap_start))
         $display("FAIL collisions got %0d exp %0d", colls, int'(both) + int'(coll_at > 0) + int'(cap_start));
      else passed++;
   endtask

   task automatic test_mult();
      run_op(1'b0, 32'd7, 32'd6, 1'b0, 0, 0, 1'b0);
      repeat (3) run_op(1'b0, $urandom, $urandom, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic test_div();
      logic [31:0] b;
      run_op(1'b1, 32'd100, 32'd7, 1'b0, 0, 0, 1'b0);
      repeat (3) begin
         b = $urandom_range(1, 5000);
         run_op(1'b1, $urandom, b, 1'b0, 0, 0, 1'b0);
      end
   endtask

   task automatic test_div_by_zero();
      FromA = $urandom;
      FromB = 32'd0;
      DivStart = 1'b1;
      step();
      DivStart = 1'b0;
      checks++; if (Div0Exc !== 1'b1) $display("FAIL dz_exc got %b exp 1", Div0Exc); else passed++;
      checks++; if (Busy !== 1'b0) $display("FAIL dz_busy got %b exp 0", Busy); else passed++;
      checks++; if (HIReg !== exp_hi || LOReg !== exp_lo) $display("FAIL dz_hilo got %h_%h exp %h_%h", HIReg, LOReg, exp_hi, exp_lo); else passed++;
      for (int k = 0; k < 5; k++) begin
         checks++; if (DivCtrl !== 1'b0) $display("FAIL dz_divctrl cyc=%0d got %b exp 0", k, DivCtrl); else passed++;
         step();
         checks++; if (Div0Exc !== 1'b0 || Busy !== 1'b0) $display("FAIL dz_after cyc=%0d got exc=%b busy=%b exp 0 0", k, Div0Exc, Busy); else passed++;
      end
   endtask

   task automatic test_collision();
      run_op(1'b0, 32'd3, 32'd5, 1'b1, 10, 0, 1'b0);
   endtask

   task automatic test_read_stall();
      run_op(1'b0, $urandom, $urandom, 1'b0, 0, 5, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] b;
      b = $urandom_range(1, 300);
      run_op(1'b1, $urandom, b, 1'b0, 0, 0, 1'b1);
      run_op(1'b0, $urandom, $urandom, 1'b0, 0, 0, 1'b1);
      b = $urandom_range(1, 70000);
      run_op(1'b1, $urandom, b, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic test_unit_div0();
      int m;
      m = $urandom_range(3, 25);
      FromA = $urandom;
      FromB = $urandom_range(1, 1000);
      DivStart = 1'b1;
      step();
      DivStart = 1'b0;
      for (int k = 0; k <= m + 2; k++) begin
         checks++; if (Busy !== (k <= m) || DivCtrl !== (k <= m)) $display("FAIL ud0_run cyc=%0d got busy=%b ctrl=%b exp %b", k, Busy, DivCtrl, k <= m); else passed++;
         checks++; if (Div0Exc !== (k == m + 1)) $display("FAIL ud0_exc cyc=%0d got %b exp %b", k, Div0Exc, k == m + 1); else passed++;
         checks++; if (Done !== 1'b0) $display("FAIL ud0_done cyc=%0d got %b exp 0", k, Done); else passed++;
         checks++; if (HIReg !== exp_hi || LOReg !== exp_lo) $display("FAIL ud0_hilo cyc=%0d got %h_%h exp %h_%h", k, HIReg, LOReg, exp_hi, exp_lo); else passed++;
         UnitDiv0 = (k == m);
         if (k < m + 2) step();
      end
      UnitDiv0 = 1'b0;
   endtask

   task automatic test_reset_mid();
      int dones;
      FromA = $urandom;
      FromB = $urandom_range(1, 1000);
      DivStart = 1'b1;
      step();
      DivStart = 1'b0;
      repeat (20) step();
      checks++; if (Busy !== 1'b1 || DivCtrl !== 1'b1) $display("FAIL rm_pre got busy=%b ctrl=%b exp 1 1", Busy, DivCtrl); else passed++;
      Reset = 1'b0;
      step();
      Reset = 1'b1;
      checks++; if (Busy !== 1'b0 || DivCtrl !== 1'b0 || MultCtrl !== 1'b0) $display("FAIL rm_ctrl got busy=%b div=%b mult=%b exp 0 0 0", Busy, DivCtrl, MultCtrl); else passed++;
      checks++; if ({HIReg, LOReg, OpA, OpB} !== 128'd0) $display("FAIL rm_regs got %h_%h_%h_%h exp 0", HIReg, LOReg, OpA, OpB); else passed++;
      checks++; if (Done !== 1'b0 || Div0Exc !== 1'b0 || Collision !== 1'b0 || UnitRst !== 1'b1) $display("FAIL rm_flags got d=%b z=%b c=%b r=%b exp 0 0 0 1", Done, Div0Exc, Collision, UnitRst); else passed++;
      exp_hi = '0;
      exp_lo = '0;
      dones = 0;
      repeat (40) begin
         step();
         if (Done === 1'b1) dones++;
      end
      checks++; if (dones !== 0) $display("FAIL rm_nodone got %0d exp 0", dones); else passed++;
      run_op(1'b0, $urandom, $urandom, 1'b0, 0, 0, 1'b0);
   endtask

   initial begin
      Reset = 1'b0; MultStart = 1'b0; DivStart = 1'b0; HiLoRead = 1'b0; UnitDiv0 = 1'b0;
      FromA = '0; FromB = '0;
      test_reset();
      test_mult();
      test_div();
      test_div_by_zero();
      test_collision();
      test_read_stall();
      test_back_to_back();
      test_unit_div0();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencer between the main control unit and the iterative Mult/Div datapath units. It latches operands, starts exactly one unit, counts its fixed iteration budget and captures its results into the architectural HI/LO registers. It also raises the divide-by-zero exception and stalls HI/LO reads while an operation is in flight.

Parameters:
MULT_CYCLES, 33, cycles the Mult unit needs from ctrl assertion to valid HI/LO outputs.
DIV_CYCLES, 34, cycles the Div unit needs from ctrl assertion to valid HI/LO outputs.
CNT_W, 6, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-low reset
MultStart  in  1  one-cycle request from control unit to start a multiply
DivStart  in  1  one-cycle request from control unit to start a divide
FromA  in  32  operand A, valid in the Start cycle
FromB  in  32  operand B, valid in the Start cycle
HiLoRead  in  1  control unit is executing mfhi/mflo this cycle
MultHI, MultLO  in  32 each  Mult unit results
DivHI, DivLO  in  32 each  Div unit results
UnitDiv0  in  1  Div unit's own Div0 flag
OpA, OpB  out  32 each  latched operands driven to both units
MultCtrl  out  1  held high while Mult runs
DivCtrl  out  1  held high while Div runs
UnitRst  out  1  active-high reset to both units
HIReg, LOReg  out  32 each  architectural HI/LO
Busy  out  1  operation in flight
Done  out  1  one-cycle completion pulse
Div0Exc  out  1  one-cycle divide-by-zero exception pulse
Collision  out  1  one-cycle pulse when a start request is dropped
ReadStall  out  1  combinational: HiLoRead && Busy

Behaviour:
- Reset (Reset==0 at an edge) sets: state IDLE, cnt=0, OpA=OpB=HIReg=LOReg=0, MultCtrl=DivCtrl=0, Busy=Done=Div0Exc=Collision=0. Reset mid-operation aborts; HI/LO are cleared.
- States: IDLE, RUN_MULT, RUN_DIV, CAPTURE.
- IDLE: UnitRst=1, Busy=0.
  - On MultStart at edge E0: latch OpA/OpB, cnt=0, MultCtrl=1, Busy=1, go to RUN_MULT.
  - On DivStart with FromB!=0: same, but DivCtrl=1 and go to RUN_DIV.
  - On DivStart with FromB==0: Div0Exc=1 for one cycle. Stay IDLE. Div unit is not started; HI/LO unchanged.
  - If MultStart and DivStart arrive together: multiply wins and Collision pulses.
- RUN_x: UnitRst=0. cnt increments every cycle. When cnt==N-1 (N = MULT_CYCLES or DIV_CYCLES), go to CAPTURE; ctrl stays high.
  - In RUN_DIV, UnitDiv0==1 sets Div0Exc pulse, drops DivCtrl and returns to IDLE. HI/LO unchanged; Done is not asserted.
- CAPTURE:
  - HIReg/LOReg <= the selected unit's HI/LO.
  - MultCtrl=DivCtrl=0, Busy=0, Done=1 for one cycle.
  - Go to IDLE.
- Latency: Start sampled at E0 -> Done high in the cycle after edge E(N+1). Next Start is accepted at E(N+2) at the earliest.
- Any Start while Busy or in CAPTURE is dropped and Collision pulses.
- HI/LO change only in CAPTURE or reset.
- ReadStall holds the pipeline until Busy falls. HIReg/LOReg are already valid in the cycle Busy falls.

Optional Feature:
MULDIV_ABORT_EN: adds input Abort (1 bit).
- Abort high in RUN_x: drop ctrl, go to IDLE next edge. Busy falls and HI/LO are unchanged; no Done or Div0Exc pulse.
- Abort in IDLE or CAPTURE has no effect; CAPTURE still completes.
- Without the macro the port does not exist and operations always run to completion.

Decomposition:
- Package muldiv_pkg holds: the state enum (IDLE, RUN_MULT, RUN_DIV, CAPTURE), the MULT_CYCLES/DIV_CYCLES default constants, and the 32-bit word typedef.
- One sub-module, muldiv_cnt: a loadable iteration counter with a terminal-count output for cnt==N-1.
- FSM, operand latches and HI/LO registers stay in the top module.

Test Plan:
- MultStart, A=7, B=6; stub MultHI=0, MultLO=42 -> MultCtrl high for 34 cycles, Done one cycle after E34, HIReg=0, LOReg=42, Busy low at the same time.
- DivStart, A=100, B=7; stub DivHI=2, DivLO=14 -> DivCtrl high for 35 cycles, Done after E35, HIReg=2, LOReg=14.
- DivStart, B=0 -> Div0Exc pulses at E1, DivCtrl never high, HI/LO keep their prior values, Busy stays 0.
- MultStart and DivStart together (A=3, B=5) -> multiply runs, Collision pulses once. DivStart again at cnt=10 -> another Collision pulse and no effect on the result.
- HiLoRead held from E5 of a multiply -> ReadStall=1 until Busy falls, then 0.
- Reset=0 at cnt=20 of a divide -> next cycle all outputs are at reset values, Done never pulses. A new MultStart after reset completes normally.
